// File: rtl/uart_tx_arb.sv
// Shares one uart_tx between N_REQ byte requesters: grant, wait for end of frame, report done.
// Define UART_ARB_RR_EN for round-robin selection; without it the lowest-index request wins.
module uart_tx_arb #(
   parameter int N_REQ = 4,
   parameter int OWN_W = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_busy,
   input  logic               tx_end,
   output logic [OWN_W-1:0]   owner,
   output logic               arb_busy
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   state_t             state, state_nxt;
   logic               grant_now, end_now;
   logic [OWN_W-1:0]   sel, sel_lo;
   logic [7:0]         sel_data;
   logic [N_REQ-1:0]   gnt_nxt, done_nxt;

`ifdef UART_ARB_RR_EN
   logic [OWN_W-1:0]   last, sel_hi;
   logic               found_hi;
`endif

   always_comb begin
      state_nxt = state;
      grant_now = 1'b0;
      end_now   = 1'b0;
      case (state)
         IDLE: if (!tx_busy && |req) begin
            grant_now = 1'b1;
            state_nxt = SEND;
         end
         SEND: state_nxt = WAIT;
         WAIT: if (tx_end) begin
            end_now   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Descending scans so the lowest matching index is the last one written.
   always_comb begin
      sel_lo = '0;
`ifdef UART_ARB_RR_EN
      sel_hi   = '0;
      found_hi = 1'b0;
`endif
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) sel_lo = OWN_W'(i);
`ifdef UART_ARB_RR_EN
         if (req[i] && (OWN_W'(i) > last)) begin
            sel_hi   = OWN_W'(i);
            found_hi = 1'b1;
         end
`endif
      end
`ifdef UART_ARB_RR_EN
      sel = found_hi ? sel_hi : sel_lo;
`else
      sel = sel_lo;
`endif
   end

   always_comb begin
      sel_data = 8'h00;
      gnt_nxt  = '0;
      done_nxt = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel == OWN_W'(i)) sel_data = req_data[8*i +: 8];
         gnt_nxt[i]  = grant_now && (sel == OWN_W'(i));
         done_nxt[i] = end_now && (owner == OWN_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         gnt      <= '0;
         done     <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         owner    <= '0;
         arb_busy <= 1'b0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         done     <= done_nxt;
         tx_start <= grant_now;
         arb_busy <= (state_nxt != IDLE);
         if (grant_now) begin
            tx_data <= sel_data;
            owner   <= sel;
         end
      end
   end

`ifdef UART_ARB_RR_EN
   // Reset value makes requester 0 the first in line.
   always_ff @(posedge clk) begin
      if (!reset)
         last <= OWN_W'(N_REQ - 1);
      else if (end_now)
         last <= owner;
   end
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb; uart_tx handshakes are driven by hand.
module tb_uart_tx_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt, done;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy, tx_end;
   logic [1:0]  owner;
   logic        arb_busy;

   int n_cmp = 0;
   int n_err = 0;

   uart_tx_arb #(.N_REQ(4), .OWN_W(2)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data),
      .gnt(gnt), .done(done), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(tx_busy), .tx_end(tx_end), .owner(owner), .arb_busy(arb_busy)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; req = 4'b0000; req_data = 32'h0; tx_busy = 1'b0; tx_end = 1'b0;
      tick(); tick();
      n_cmp++;
      if ({tx_start, arb_busy, gnt, done} !== 10'b0_0_0000_0000) begin
         n_err++; $display("[TB] FAIL reset_status: got %b want %b", {tx_start, arb_busy, gnt, done}, 10'b0);
      end
      n_cmp++;
      if ({tx_data, owner} !== 10'h000) begin
         n_err++; $display("[TB] FAIL reset_data_owner: got %h/%0d want 00/0", tx_data, owner);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single();
      req = 4'b0001; req_data = 32'h0000_0041;
      tick();
      n_cmp++;
      if ({tx_start, arb_busy, gnt, done} !== 10'b1_1_0001_0000) begin
         n_err++; $display("[TB] FAIL single_grant: got %b want %b", {tx_start, arb_busy, gnt, done}, 10'b1_1_0001_0000);
      end
      n_cmp++;
      if (tx_data !== 8'h41 || owner !== 2'd0) begin
         n_err++; $display("[TB] FAIL single_data: got %h/%0d want 41/0", tx_data, owner);
      end
      req = 4'b0000; tx_busy = 1'b1;
      tick();
      n_cmp++;
      if ({tx_start, arb_busy, gnt, done} !== 10'b0_1_0000_0000) begin
         n_err++; $display("[TB] FAIL single_wait: got %b want %b", {tx_start, arb_busy, gnt, done}, 10'b0_1_0000_0000);
      end
      for (int i = 0; i < 9; i++) tick();
      tx_end = 1'b1; tx_busy = 1'b0;
      tick();
      tx_end = 1'b0;
      n_cmp++;
      if ({tx_start, arb_busy, gnt, done} !== 10'b0_0_0000_0001) begin
         n_err++; $display("[TB] FAIL single_done: got %b want %b", {tx_start, arb_busy, gnt, done}, 10'b0_0_0000_0001);
      end
      tick();
      n_cmp++;
      if (done !== 4'b0000) begin
         n_err++; $display("[TB] FAIL single_done_width: got %b want 0000", done);
      end
   endtask

   task automatic test_back_to_back();
      int exp_own [5];
      logic [3:0] eg;
`ifdef UART_ARB_RR_EN
      exp_own = '{0, 1, 2, 3, 0};
`else
      exp_own = '{0, 0, 0, 0, 0};
`endif
      reset = 1'b0;
      tick();
      reset = 1'b1;
      req = 4'b1111; req_data = 32'h4443_4241;
      for (int f = 0; f < 5; f++) begin
         eg = 4'b0001 << exp_own[f];
         tick();
         n_cmp++;
         if (tx_start !== 1'b1 || gnt !== eg || owner !== 2'(exp_own[f])) begin
            n_err++; $display("[TB] FAIL b2b_grant%0d: got start=%b gnt=%b owner=%0d want 1/%b/%0d", f, tx_start, gnt, owner, eg, exp_own[f]);
         end
         n_cmp++;
         if (tx_data !== 8'(8'h41 + exp_own[f])) begin
            n_err++; $display("[TB] FAIL b2b_data%0d: got %h want %h", f, tx_data, 8'(8'h41 + exp_own[f]));
         end
         tx_busy = 1'b1;
         tick(); tick(); tick();
         tx_end = 1'b1; tx_busy = 1'b0;
         tick();
         tx_end = 1'b0;
         n_cmp++;
         if (done !== eg || gnt !== 4'b0000 || arb_busy !== 1'b0) begin
            n_err++; $display("[TB] FAIL b2b_done%0d: got done=%b gnt=%b busy=%b want %b/0000/0", f, done, gnt, arb_busy, eg);
         end
      end
      req = 4'b0000;
      tick();
      n_cmp++;
      if (tx_start !== 1'b0 || arb_busy !== 1'b0) begin
         n_err++; $display("[TB] FAIL b2b_stop: got start=%b busy=%b want 0/0", tx_start, arb_busy);
      end
   endtask

   task automatic test_withdraw();
      req = 4'b0001; req_data = 32'h0000_0055;
      tick();
      n_cmp++;
      if (gnt !== 4'b0001 || tx_data !== 8'h55) begin
         n_err++; $display("[TB] FAIL wd_grant: got %b/%h want 0001/55", gnt, tx_data);
      end
      req = 4'b0000; tx_busy = 1'b1;
      tick();
      req = 4'b0100;
      tick(); tick();
      n_cmp++;
      if (gnt !== 4'b0000 || tx_start !== 1'b0) begin
         n_err++; $display("[TB] FAIL wd_in_wait: got gnt=%b start=%b want 0000/0", gnt, tx_start);
      end
      req = 4'b0000;
      tick();
      tx_end = 1'b1; tx_busy = 1'b0;
      tick();
      tx_end = 1'b0;
      n_cmp++;
      if (done !== 4'b0001) begin
         n_err++; $display("[TB] FAIL wd_done: got %b want 0001", done);
      end
      tick(); tick();
      n_cmp++;
      if ({tx_start, arb_busy, gnt, done} !== 10'b0 || owner !== 2'd0) begin
         n_err++; $display("[TB] FAIL wd_no_grant: got %b owner=%0d want 0/0", {tx_start, arb_busy, gnt, done}, owner);
      end
   endtask

   task automatic test_busy_block();
      tx_busy = 1'b1; req = 4'b0010; req_data = 32'h0000_6600;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (gnt !== 4'b0000 || tx_start !== 1'b0) begin
            n_err++; $display("[TB] FAIL busy_blocked%0d: got gnt=%b start=%b want 0000/0", i, gnt, tx_start);
         end
      end
      tx_busy = 1'b0;
      tick();
      n_cmp++;
      if (gnt !== 4'b0010 || tx_start !== 1'b1 || owner !== 2'd1 || tx_data !== 8'h66) begin
         n_err++; $display("[TB] FAIL busy_release: got gnt=%b start=%b owner=%0d data=%h want 0010/1/1/66", gnt, tx_start, owner, tx_data);
      end
      req = 4'b0000; tx_busy = 1'b1;
      tick();
      tx_end = 1'b1; tx_busy = 1'b0;
      tick();
      tx_end = 1'b0;
      n_cmp++;
      if (done !== 4'b0010) begin
         n_err++; $display("[TB] FAIL busy_done: got %b want 0010", done);
      end
      tick();
   endtask

   task automatic test_reset_wait();
      req = 4'b1000; req_data = 32'h7700_0011;
      tick();
      n_cmp++;
      if (gnt !== 4'b1000 || owner !== 2'd3 || tx_data !== 8'h77) begin
         n_err++; $display("[TB] FAIL rw_grant: got %b/%0d/%h want 1000/3/77", gnt, owner, tx_data);
      end
      req = 4'b0000; tx_busy = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n_cmp++;
      if ({tx_start, arb_busy, gnt, done} !== 10'b0 || tx_data !== 8'h00 || owner !== 2'd0) begin
         n_err++; $display("[TB] FAIL rw_reset: got %b data=%h owner=%0d want 0/00/0", {tx_start, arb_busy, gnt, done}, tx_data, owner);
      end
      req = 4'b0001;
      tick(); tick();
      n_cmp++;
      if (gnt !== 4'b0000 || tx_start !== 1'b0) begin
         n_err++; $display("[TB] FAIL rw_busy_hold: got gnt=%b start=%b want 0000/0", gnt, tx_start);
      end
      tx_end = 1'b1; tx_busy = 1'b0;
      tick();
      tx_end = 1'b0;
      n_cmp++;
      if (done !== 4'b0000 || gnt !== 4'b0001 || tx_start !== 1'b1) begin
         n_err++; $display("[TB] FAIL rw_stale_end: got done=%b gnt=%b start=%b want 0000/0001/1", done, gnt, tx_start);
      end
      req = 4'b0000; tx_busy = 1'b1;
      tick();
      tx_end = 1'b1; tx_busy = 1'b0;
      tick();
      tx_end = 1'b0;
      n_cmp++;
      if (done !== 4'b0001) begin
         n_err++; $display("[TB] FAIL rw_done: got %b want 0001", done);
      end
      tick();
   endtask

   task automatic test_stray_end();
      req = 4'b0000; tx_end = 1'b1;
      tick();
      tx_end = 1'b0;
      n_cmp++;
      if ({tx_start, arb_busy, gnt, done} !== 10'b0) begin
         n_err++; $display("[TB] FAIL stray_end: got %b want 0", {tx_start, arb_busy, gnt, done});
      end
      req = 4'b0100; req_data = 32'h0099_0000;
      tick();
      n_cmp++;
      if (gnt !== 4'b0100 || owner !== 2'd2 || tx_data !== 8'h99) begin
         n_err++; $display("[TB] FAIL stray_then_grant: got %b/%0d/%h want 0100/2/99", gnt, owner, tx_data);
      end
      req = 4'b0000; tx_busy = 1'b1;
      tick();
      tx_end = 1'b1; tx_busy = 1'b0;
      tick();
      tx_end = 1'b0;
      n_cmp++;
      if (done !== 4'b0100) begin
         n_err++; $display("[TB] FAIL stray_done: got %b want 0100", done);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_withdraw();
      test_busy_block();
      test_reset_wait();
      test_stray_end();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one `uart_tx` transmitter between `N_REQ` byte requesters, for example the CPU bus path through `uart_ctrl` and debug/monitor sources.

- It sits between the requesters and `uart_tx`.
- It selects one pending request, drives `tx_start`/`tx_data` and waits for `tx_end`.
- It then reports completion to the owner and rotates priority.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `OWN_W`, default 2: width of `owner`; must be ≥ ceil(log2(N_REQ)).

Ports:
- `clk`  in  1  system clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  N_REQ  per-requester send request, level.
- `req_data`  in  8*N_REQ  byte of requester i on bits [8i+7:8i].
- `gnt`  out  N_REQ  one-cycle pulse: byte of requester i accepted.
- `done`  out  N_REQ  one-cycle pulse: byte of requester i fully shifted out.
- `tx_start`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_data`  out  8  byte to `uart_tx`, registered.
- `tx_busy`  in  1  from `uart_tx`.
- `tx_end`  in  1  from `uart_tx`, one-cycle end-of-frame pulse.
- `owner`  out  OWN_W  index of the current or last granted requester.
- `arb_busy`  out  1  high while a transfer is owned (state SEND or WAIT).

## Operation
- FSM states:
  - IDLE: no transfer owned.
  - SEND: one cycle; `tx_start`, `gnt[owner]` and `tx_data` are valid.
  - WAIT: transfer in flight.
- IDLE → SEND when `tx_busy`==0 and `req`!=0.
  - In that cycle the arbiter computes `sel`, registers `tx_data`←`req_data[sel]` and `owner`←`sel`.
  - It sets `tx_start`, `gnt[sel]` and `arb_busy` for the next cycle.
- SEND → WAIT unconditionally. `tx_start` and `gnt` drop.
- WAIT → IDLE on `tx_end`==1.
  - Registers `done[owner]`=1 for one cycle.
  - Sets `last`←`owner` and clears `arb_busy`.
  - No arbitration takes place in that cycle.
- Selection with the macro defined: round-robin.
  - The search starts at `last+1` and wraps from index N_REQ-1 to index 0.
  - The first set `req` bit wins.
- Requester rule: hold `req` and `req_data` stable until `gnt`, then deassert or present the next byte.
  - Dropping `req` before `gnt` withdraws the request with no side effect.
  - A `req` still high in the cycle after `gnt` counts as a new request.
- `tx_end` seen in IDLE or SEND is ignored. It can only come from a frame started before reset.
- `tx_busy`==1 in IDLE blocks granting. This covers a frame left running by a mid-operation reset.
- Reset (synchronous, `reset`==0) clears:
  - state→IDLE;
  - `gnt`, `done`, `tx_start` and `arb_busy`→0;
  - `tx_data`→8'h00 and `owner`→0;
  - `last`→N_REQ-1, so requester 0 has highest priority after reset.
- An in-flight `uart_tx` frame is not aborted; the arbiter waits for `tx_busy` to fall.

## Timing
- Every output is registered. Reset values are as listed under Operation.
- Request to start: `req` sampled high at edge T (IDLE, `tx_busy`=0) → `tx_start`, `gnt` and `tx_data` are valid during cycle T+1.
- Completion: `tx_end` high at edge E → `done[owner]` high during E+1, state IDLE in E+1.
- Back-to-back: earliest next `tx_start` is in cycle E+2.
  - This holds provided `uart_tx` has dropped `tx_busy` by E+1.
  - Otherwise the next `tx_start` follows in the first cycle after `tx_busy` is seen low.
- `gnt` and `done` are exactly one cycle wide and never high for two requesters in the same cycle.
- Only `gnt` or only `done` is high in any one cycle. They cannot coincide for the same transfer, because SEND is at least one cycle before WAIT.

## Configuration
- Macro: `UART_ARB_RR_EN`.
- Defined: round-robin selection using the `last` register, as described under Operation.
- Undefined: fixed priority.
  - The lowest-index set `req` always wins.
  - The `last` register is not built.
  - All FSM behaviour and timing are otherwise identical.

## Test plan
- Reset, then `req`=4'b0001 with data 8'h41 → `tx_start` and `gnt`=4'b0001 one cycle later, `tx_data`=8'h41, `owner`=0. Model `tx_end` 10 cycles later → `done`=4'b0001 next cycle, `arb_busy`=0.
- `req`=4'b1111 held, each requester re-requesting after its `gnt`, with RR enabled → grant order 0,1,2,3,0. With the macro undefined → grant order 0,0,0…
- `req[2]` raised and then dropped before the cycle in which IDLE is reached → no `gnt`, no `tx_start`, `owner` unchanged.
- `tx_busy` held 1 in IDLE with `req`=4'b0010 → no grant until `tx_busy` falls. Grant appears one cycle after `tx_busy` is sampled 0.
- Assert `reset`=0 during WAIT → all outputs reset next cycle. A subsequent `tx_end` is ignored and produces no `done`. A new `req` is granted only after `tx_busy`=0.
- Stray `tx_end` pulse in IDLE with `req`=0 → `done` stays 4'b0000 and state stays IDLE.
